dmem_access_ctrl: RTL and testbench

Multi-cycle data-memory access controller for the MEM stage of the 5-stage pipeline. It takes the MemRead/MemWrite controls and address/data from the EX/MEM register and runs a req/ack handshake with a variable-latency data memory. While an access is outstanding it freezes the pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) through one stall line. It presents load data to the MEM/WB register's data-memory input, stable in the cycle the pipeline advances.

---
 rtl/dmem_access_ctrl.sv | 119 +++++++++++
 tb/tb_dmem_access_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: req/ack handshake with a variable-latency memory.
// Latency: an op enters ACCESS one cycle after it appears and is released in DONE, one cycle after ack or timeout.
// Backpressure: stall_o freezes the whole pipeline from the op's first cycle through its last ACCESS cycle.
module dmem_access_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                mem_op;

    assign mem_op = MemRead_i | MemWrite_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    we_d    = MemWrite_i;
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // An ack on the limit cycle takes priority over the timeout.
                if (mem_ack_i) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata_i;
                    end
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = '0;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request is decoded from state so an async reset drops it without a clock edge.
    assign mem_req_o   = (state_q == ACCESS);
    assign stall_o     = ((state_q == IDLE) && mem_op) || (state_q == ACCESS);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench: per-op timelines are derived from the handshake timing rules and checked every cycle.
module tb_dmem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall;
    logic [31:0] rdata;
    logic        req;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        ack = 1'b0;
    logic [31:0] mrdata = '0;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    dmem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .MemRead_i   (mem_read),
        .MemWrite_i  (mem_write),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .stall_o     (stall),
        .rdata_o     (rdata),
        .mem_req_o   (req),
        .mem_we_o    (we),
        .mem_addr_o  (maddr),
        .mem_wdata_o (mwdata),
        .mem_ack_i   (ack),
        .mem_rdata_i (mrdata),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    // Architectural view of the controller: last latched request, last load result, sticky error.
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : cmp
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("stall_o", 32'(stall), 32'(e.stall));
            chk("mem_req_o", 32'(req), 32'(e.req));
            chk("mem_we_o", 32'(we), 32'(e.we));
            chk("mem_addr_o", maddr, e.addr);
            chk("mem_wdata_o", mwdata, e.wdata);
            chk("rdata_o", rdata, e.rdata);
            chk("err_o", 32'(err), 32'(e.err));
        end
    end

    task automatic push(input logic s, input logic r);
        exp_t e;
        e.stall = s;
        e.req   = r;
        e.we    = m_we;
        e.addr  = m_addr;
        e.wdata = m_wdata;
        e.rdata = m_rdata;
        e.err   = m_err;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic ak, input logic [31:0] ad);
        @(posedge clk);
        #1;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        ack       = ak;
        mrdata    = ad;
    endtask

    task automatic model_clear();
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_rdata = '0;
        m_err   = 1'b0;
    endtask

    task automatic idle(input int n, input logic spur);
        for (int i = 0; i < n; i++) begin
            next_cycle(1'b0, 1'b0, 32'hFFFF_FFF0 ^ i, 32'h0F0F_0000 + i, spur, 32'h5A5A_5A5A);
            push(1'b0, 1'b0);
        end
    endtask

    // n_wait < 0 means the memory never acks. Address/data inputs are perturbed
    // during ACCESS so that only the latched copies can produce the expected outputs.
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input int n_wait, input logic [31:0] ad);
        bit acked;
        int n_acc;
        acked = (n_wait >= 0) && (n_wait < TO);
        n_acc = acked ? n_wait + 1 : TO;
        next_cycle(rd, wr, a, wd, 1'b0, ~ad);
        push(1'b1, 1'b0);
        m_we    = wr;
        m_addr  = a;
        m_wdata = wd;
        for (int i = 0; i < n_acc; i++) begin
            if (acked && i == n_wait)
                next_cycle(rd, wr, a ^ 32'h0000_FF00, ~wd, 1'b1, ad);
            else
                next_cycle(rd, wr, a ^ 32'h0000_FF00, ~wd, 1'b0, ~ad);
            push(1'b1, 1'b1);
        end
        if (acked) begin
            if (!wr) m_rdata = ad;
        end else begin
            m_err = 1'b1;
            if (!wr) m_rdata = '0;
        end
        // Release cycle; an ack here is spurious and must be ignored.
        next_cycle(rd, wr, a, wd, 1'b1, 32'hFFFF_0000);
        push(1'b0, 1'b0);
    endtask

    initial begin
        model_clear();
        #12;
        chk("reset stall_o", 32'(stall), 32'h0);
        chk("reset mem_req_o", 32'(req), 32'h0);
        chk("reset mem_addr_o", maddr, 32'h0);
        chk("reset rdata_o", rdata, 32'h0);
        chk("reset err_o", 32'(err), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2, 1'b0);

        // Zero-wait load.
        do_op(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF);
        chk("load0 rdata_o", rdata, 32'hDEAD_BEEF);
        chk("load0 stall_o in DONE", 32'(stall), 32'h0);
        idle(1, 1'b0);

        // Store with three wait states; load data must be untouched.
        do_op(1'b0, 1'b1, 32'h20, 32'h1234_5678, 3, 32'h7777_7777);
        chk("store rdata_o kept", rdata, 32'hDEAD_BEEF);
        chk("store mem_wdata_o", mwdata, 32'h1234_5678);
        idle(1, 1'b0);

        // Ack coinciding with the timeout limit.
        do_op(1'b1, 1'b0, 32'h30, 32'h0, TO - 1, 32'hA5A5_A5A5);
        chk("limit-ack rdata_o", rdata, 32'hA5A5_A5A5);
        chk("limit-ack err_o", 32'(err), 32'h0);

        // Back-to-back loads, then both controls high.
        do_op(1'b1, 1'b0, 32'h40, 32'h0, 1, 32'h1111_1111);
        do_op(1'b1, 1'b0, 32'h44, 32'h0, 0, 32'h2222_2222);
        chk("b2b rdata_o", rdata, 32'h2222_2222);
        do_op(1'b1, 1'b1, 32'h50, 32'hCAFE_F00D, 0, 32'h3333_3333);
        chk("rd+wr mem_we_o", 32'(we), 32'h1);
        chk("rd+wr rdata_o kept", rdata, 32'h2222_2222);

        idle(3, 1'b1);

        // Timeout on a load, then a successful load keeps err_o set.
        do_op(1'b1, 1'b0, 32'h60, 32'h0, -1, 32'h4444_4444);
        chk("timeout err_o", 32'(err), 32'h1);
        chk("timeout rdata_o", rdata, 32'h0);
        chk("timeout stall_o released", 32'(stall), 32'h0);
        do_op(1'b1, 1'b0, 32'h64, 32'h0, 0, 32'h0BAD_F00D);
        chk("sticky err_o", 32'(err), 32'h1);
        chk("post-timeout rdata_o", rdata, 32'h0BAD_F00D);

        // Reset in the middle of an access.
        next_cycle(1'b1, 1'b0, 32'h70, 32'h0, 1'b0, 32'h0);
        push(1'b1, 1'b0);
        m_we   = 1'b0;
        m_addr = 32'h70;
        next_cycle(1'b1, 1'b0, 32'h70, 32'h0, 1'b0, 32'h0);
        push(1'b1, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset mem_req_o", 32'(req), 32'h0);
        chk("async reset stall_o (op present)", 32'(stall), 32'h1);
        chk("async reset mem_addr_o", maddr, 32'h0);
        mem_read = 1'b0;
        #1;
        chk("async reset stall_o (no op)", 32'(stall), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        idle(3, 1'b1);
        chk("post-reset rdata_o", rdata, 32'h0);
        chk("post-reset err_o", 32'(err), 32'h0);
        do_op(1'b1, 1'b0, 32'h80, 32'h0, 2, 32'h1357_9BDF);
        chk("post-reset load rdata_o", rdata, 32'h1357_9BDF);
        idle(2, 1'b0);

        @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL expectation queue drained: got %0d left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
